// File: rtl/dmac_channel_arbiter.sv
// Round-robin arbiter sharing one AHB master port between NUM_CH DMA channels.
// Holds each grant until the channel's irq or an AHB ERROR, then drains the last data phase.
module dmac_channel_arbiter #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned IDW    = $clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      dma_req,
    input  logic [NUM_CH-1:0]      irq_clr,
    input  logic [NUM_CH-1:0]      ch_irq,
    input  logic [2*NUM_CH-1:0]    ch_htrans,
    input  logic [NUM_CH-1:0]      ch_write,
    input  logic [32*NUM_CH-1:0]   ch_maddr,
    input  logic [32*NUM_CH-1:0]   ch_mwdata,
    input  logic                   HReady,
    input  logic [1:0]             HResp,
    output logic [NUM_CH-1:0]      ch_en,
    output logic [NUM_CH-1:0]      ch_ready,
    output logic [1:0]             HTrans,
    output logic                   HWrite,
    output logic [31:0]            HAddr,
    output logic [31:0]            HWData,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy,
    output logic [NUM_CH-1:0]      done_stat,
    output logic [NUM_CH-1:0]      err_stat,
    output logic                   irq
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

    state_e              state_q, state_d;
    logic [IDW-1:0]      grant_q, grant_d;
    logic [IDW-1:0]      last_q, last_d;
    logic [NUM_CH-1:0]   en_q, en_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic [NUM_CH-1:0]   err_q, err_d;
    logic                busy_q, busy_d;
    logic                irq_q, irq_d;

    logic [NUM_CH-1:0]   elig;
    logic [NUM_CH-1:0]   set_done, set_err;
    logic                found;
    logic [IDW-1:0]      sel, cand;

    // A channel with pending status must be cleared by software before it can retrigger.
    assign elig = dma_req & ~done_q & ~err_q;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = IDW'((32'(last_q) + k) % NUM_CH);
            if (!found && elig[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        set_done = '0;
        set_err  = '0;
        en_d     = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = sel;
                    last_d  = sel;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                // ERROR wins over a coincident completion irq.
                if (HResp == 2'b01 && !HReady) begin
                    set_err[grant_q] = 1'b1;
                    state_d          = DRAIN;
                end else if (ch_irq[grant_q]) begin
                    set_done[grant_q] = 1'b1;
                    state_d           = DRAIN;
                end
            end
            DRAIN: begin
                if (HReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Set beats clear on a same-cycle collision.
        done_d = (done_q & ~irq_clr) | set_done;
        err_d  = (err_q & ~irq_clr) | set_err;

        if (state_d == ACTIVE) begin
            en_d[grant_d] = 1'b1;
        end
        busy_d = (state_d != IDLE);
        irq_d  = |(done_d | err_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDW'(NUM_CH - 1);
            en_q    <= '0;
            done_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            irq_q   <= irq_d;
        end
    end

    // Bus steering: address/data/write stay muxed through DRAIN, HTrans only while ACTIVE.
    always_comb begin
        HTrans   = 2'b00;
        HWrite   = 1'b0;
        HAddr    = '0;
        HWData   = '0;
        ch_ready = '0;
        if (state_q != IDLE) begin
            HWrite            = ch_write[grant_q];
            HAddr             = ch_maddr[{grant_q, 5'b0} +: 32];
            HWData            = ch_mwdata[{grant_q, 5'b0} +: 32];
            ch_ready[grant_q] = HReady;
        end
        if (state_q == ACTIVE) begin
            HTrans = ch_htrans[{grant_q, 1'b0} +: 2];
        end
    end

    assign ch_en     = en_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign done_stat = done_q;
    assign err_stat  = err_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_dmac_channel_arbiter.sv
// Bench for dmac_channel_arbiter: directed vector table, then random traffic against
// a transaction-level model of the bus owner and per-channel status.
module tb_dmac_channel_arbiter;

    localparam int unsigned N = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  dma_req, irq_clr, ch_irq, ch_write;
    logic [2*N-1:0]  ch_htrans;
    logic [32*N-1:0] ch_maddr, ch_mwdata;
    logic          HReady;
    logic [1:0]    HResp;
    logic [N-1:0]  ch_en, ch_ready, done_stat, err_stat;
    logic [1:0]    HTrans;
    logic          HWrite, busy, irq;
    logic [31:0]   HAddr, HWData;
    logic [0:0]    grant_id;

    int checks = 0;
    int errors = 0;

    dmac_channel_arbiter #(.NUM_CH(N)) dut (
        .clk(clk), .rst(rst), .dma_req(dma_req), .irq_clr(irq_clr), .ch_irq(ch_irq),
        .ch_htrans(ch_htrans), .ch_write(ch_write), .ch_maddr(ch_maddr), .ch_mwdata(ch_mwdata),
        .HReady(HReady), .HResp(HResp), .ch_en(ch_en), .ch_ready(ch_ready), .HTrans(HTrans),
        .HWrite(HWrite), .HAddr(HAddr), .HWData(HWData), .grant_id(grant_id), .busy(busy),
        .done_stat(done_stat), .err_stat(err_stat), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] req, irqc, clr;
        logic       hrdy;
        logic [1:0] hresp;
        logic [1:0] e_en;
        logic       e_busy;
        logic       e_gnt;
        logic [1:0] e_done, e_err;
        logic       e_irq;
        logic [1:0] e_ht;
        logic [31:0] e_addr;
        logic [1:0] e_rdy;
    } vec_t;

    localparam int NV = 25;
    vec_t vt[NV];

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0000;

    // Transaction-level reference: who owns the bus, whether it is draining, status flags.
    int         m_owner;
    bit         m_drain;
    int         m_last, m_grant;
    logic [N-1:0] m_done, m_err;

    task automatic model_reset();
        m_owner = -1; m_drain = 0; m_last = N - 1; m_grant = 0;
        m_done = '0; m_err = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] sd, se;
        sd = '0; se = '0;
        if (rst) begin
            model_reset();
        end else begin
            if (m_owner < 0) begin
                for (int i = 1; i <= N; i++) begin
                    int c;
                    c = (m_last + i) % N;
                    if (m_owner < 0 && dma_req[c] && !m_done[c] && !m_err[c]) begin
                        m_owner = c; m_last = c; m_grant = c; m_drain = 0;
                    end
                end
            end else if (!m_drain) begin
                if (HResp == 2'b01 && !HReady) begin
                    se[m_owner] = 1'b1; m_drain = 1;
                end else if (ch_irq[m_owner]) begin
                    sd[m_owner] = 1'b1; m_drain = 1;
                end
            end else if (HReady) begin
                m_owner = -1; m_drain = 0;
            end
            m_done = (m_done & ~irq_clr) | sd;
            m_err  = (m_err & ~irq_clr) | se;
        end
    endtask

    task automatic model_compare(input int cyc);
        logic [N-1:0] e_en, e_rdy;
        logic [1:0]   e_ht;
        logic [31:0]  e_addr, e_wd;
        logic         e_wr;
        e_en = '0; e_rdy = '0; e_ht = 2'b00; e_addr = '0; e_wd = '0; e_wr = 1'b0;
        if (m_owner >= 0) begin
            e_addr = 32'(ch_maddr >> (32 * m_owner));
            e_wd   = 32'(ch_mwdata >> (32 * m_owner));
            e_wr   = ch_write[m_owner];
            e_rdy[m_owner] = HReady;
            if (!m_drain) begin
                e_en[m_owner] = 1'b1;
                e_ht = 2'(ch_htrans >> (2 * m_owner));
            end
        end
        chk($sformatf("rnd%0d ch_en", cyc), 64'(ch_en), 64'(e_en));
        chk($sformatf("rnd%0d busy", cyc), 64'(busy), 64'(m_owner >= 0));
        chk($sformatf("rnd%0d grant_id", cyc), 64'(grant_id), 64'(m_grant));
        chk($sformatf("rnd%0d done_stat", cyc), 64'(done_stat), 64'(m_done));
        chk($sformatf("rnd%0d err_stat", cyc), 64'(err_stat), 64'(m_err));
        chk($sformatf("rnd%0d irq", cyc), 64'(irq), 64'(|(m_done | m_err)));
        chk($sformatf("rnd%0d HTrans", cyc), 64'(HTrans), 64'(e_ht));
        chk($sformatf("rnd%0d HAddr", cyc), 64'(HAddr), 64'(e_addr));
        chk($sformatf("rnd%0d HWData", cyc), 64'(HWData), 64'(e_wd));
        chk($sformatf("rnd%0d HWrite", cyc), 64'(HWrite), 64'(e_wr));
        chk($sformatf("rnd%0d ch_ready", cyc), 64'(ch_ready), 64'(e_rdy));
    endtask

    initial begin
        //          rst  req    irqc   clr    rdy   hresp  en     busy gnt done   err    irq  ht     addr rdy
        vt[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0, 2'b00};
        vt[1]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, A0, 2'b01};
        vt[2]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, A0, 2'b01};
        vt[3]  = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 2'b00, A0, 2'b01};
        vt[4]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 32'h0, 2'b00};
        vt[5]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 32'h0, 2'b00};
        vt[6]  = '{1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0, 2'b00};
        vt[7]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, A0, 2'b01};
        vt[8]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 2'b00, A0, 2'b00};
        vt[9]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 2'b00, A0, 2'b00};
        vt[10] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 2'b00, 32'h0, 2'b00};
        vt[11] = '{1'b0, 2'b11, 2'b00, 2'b01, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b11, A1, 2'b10};
        vt[12] = '{1'b0, 2'b11, 2'b01, 2'b00, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b11, A1, 2'b10};
        vt[13] = '{1'b0, 2'b11, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1, 2'b00, A1, 2'b00};
        vt[14] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1, 2'b00, A1, 2'b00};
        vt[15] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1, 2'b00, A1, 2'b00};
        vt[16] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 2'b00, 32'h0, 2'b00};
        vt[17] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 2'b10, A0, 2'b01};
        vt[18] = '{1'b0, 2'b11, 2'b01, 2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 2'b00, A0, 2'b01};
        vt[19] = '{1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0, 2'b00};
        vt[20] = '{1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b11, A1, 2'b10};
        vt[21] = '{1'b1, 2'b10, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0, 2'b00};
        vt[22] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, A0, 2'b01};
        vt[23] = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 2'b00, A0, 2'b01};
        vt[24] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0, 2'b00};

        ch_htrans = 4'b11_10;
        ch_write  = 2'b01;
        ch_maddr  = {A1, A0};
        ch_mwdata = {32'h5A5A_5A5A, 32'hA5A5_A5A5};

        for (int i = 0; i < NV; i++) begin
            rst = vt[i].rst; dma_req = vt[i].req; ch_irq = vt[i].irqc; irq_clr = vt[i].clr;
            HReady = vt[i].hrdy; HResp = vt[i].hresp;
            @(posedge clk); #1;
            chk($sformatf("vec%0d ch_en", i), 64'(ch_en), 64'(vt[i].e_en));
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'(vt[i].e_busy));
            chk($sformatf("vec%0d grant_id", i), 64'(grant_id), 64'(vt[i].e_gnt));
            chk($sformatf("vec%0d done_stat", i), 64'(done_stat), 64'(vt[i].e_done));
            chk($sformatf("vec%0d err_stat", i), 64'(err_stat), 64'(vt[i].e_err));
            chk($sformatf("vec%0d irq", i), 64'(irq), 64'(vt[i].e_irq));
            chk($sformatf("vec%0d HTrans", i), 64'(HTrans), 64'(vt[i].e_ht));
            chk($sformatf("vec%0d HAddr", i), 64'(HAddr), 64'(vt[i].e_addr));
            chk($sformatf("vec%0d ch_ready", i), 64'(ch_ready), 64'(vt[i].e_rdy));
        end

        // Random traffic; the first cycle resets both DUT and model.
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst       = (cyc == 0) || ($urandom_range(0, 299) == 0);
            dma_req   = N'($urandom);
            ch_irq    = '0;
            irq_clr   = '0;
            for (int b = 0; b < N; b++) begin
                ch_irq[b]  = ($urandom_range(0, 9) == 0);
                irq_clr[b] = ($urandom_range(0, 7) == 0);
            end
            HReady    = ($urandom_range(0, 3) != 0);
            HResp     = ($urandom_range(0, 11) == 0) ? 2'b01 : 2'b00;
            ch_htrans = 4'($urandom);
            ch_write  = N'($urandom);
            ch_maddr  = {$urandom, $urandom};
            ch_mwdata = {$urandom, $urandom};
            model_step();
            @(posedge clk); #1;
            model_compare(cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
